// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between writeback and a queued long-latency unit
module rf_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbEn,
    input  logic [2:0]  wbRegSel,
    input  logic [15:0] wbData,
    input  logic        lngValid,
    input  logic [2:0]  lngRegSel,
    input  logic [15:0] lngData,
    output logic        lngReady,
    output logic        rfWriteEn,
    output logic [2:0]  rfWriteRegSel,
    output logic [15:0] rfWriteData,
    output logic [7:0]  pendingRegs,
    output logic        stallPipe,
    output logic        err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [2:0]    fifo_reg  [DEPTH];
    logic [15:0]   fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [3:0]    starve_cnt;
    logic          err_q;

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign lngReady  = ~full;
    assign push      = lngValid & ~full;
    assign stallPipe = (starve_cnt == 4'(STARVE_LIMIT));
    assign err       = err_q;

    // wb has priority unless the starvation counter has forced a drain cycle
    always_comb begin
        rfWriteEn     = 1'b0;
        rfWriteRegSel = 3'd0;
        rfWriteData   = 16'd0;
        pop           = 1'b0;
        if (!stallPipe && wbEn) begin
            rfWriteEn     = 1'b1;
            rfWriteRegSel = wbRegSel;
            rfWriteData   = wbData;
        end else if (!empty) begin
            rfWriteEn     = 1'b1;
            rfWriteRegSel = fifo_reg[rd_ptr];
            rfWriteData   = fifo_data[rd_ptr];
            pop           = 1'b1;
        end
    end

    always_comb begin
        pendingRegs = 8'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                pendingRegs[fifo_reg[rd_ptr + PW'(k)]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= lngRegSel;
            fifo_data[wr_ptr] <= lngData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop || empty) begin
                starve_cnt <= 4'd0;
            end else if (wbEn && !stallPipe) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            // dropped wb write, or wb overtaking a queued write to the same register
            if (wbEn && (stallPipe || pendingRegs[wbRegSel])) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbEn;
    logic [2:0]  wbRegSel;
    logic [15:0] wbData;
    logic        lngValid;
    logic [2:0]  lngRegSel;
    logic [15:0] lngData;
    logic        lngReady;
    logic        rfWriteEn;
    logic [2:0]  rfWriteRegSel;
    logic [15:0] rfWriteData;
    logic [7:0]  pendingRegs;
    logic        stallPipe;
    logic        err;

    int n_pass = 0;
    int n_total = 0;

    rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .wbEn(wbEn),
        .wbRegSel(wbRegSel),
        .wbData(wbData),
        .lngValid(lngValid),
        .lngRegSel(lngRegSel),
        .lngData(lngData),
        .lngReady(lngReady),
        .rfWriteEn(rfWriteEn),
        .rfWriteRegSel(rfWriteRegSel),
        .rfWriteData(rfWriteData),
        .pendingRegs(pendingRegs),
        .stallPipe(stallPipe),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic en, input logic [2:0] sel, input logic [15:0] d);
        wbEn = en; wbRegSel = sel; wbData = d;
    endtask

    task automatic set_lng(input logic v, input logic [2:0] sel, input logic [15:0] d);
        lngValid = v; lngRegSel = sel; lngData = d;
    endtask

    task automatic chk_rf(input string tag, input logic en, input logic [2:0] sel, input logic [15:0] d);
        #1;
        chk({tag, ".en"}, 16'(rfWriteEn), 16'(en));
        chk({tag, ".sel"}, 16'(rfWriteRegSel), 16'(sel));
        chk({tag, ".data"}, rfWriteData, d);
    endtask

    initial begin
        rst = 1'b1;
        set_wb(1'b0, 3'd0, 16'd0);
        set_lng(1'b0, 3'd0, 16'd0);
        tick();
        rst = 1'b0;
        chk_rf("reset", 1'b0, 3'd0, 16'd0);
        chk("reset.ready", 16'(lngReady), 16'd1);
        chk("reset.pend", 16'(pendingRegs), 16'h00);
        chk("reset.stall", 16'(stallPipe), 16'd0);
        chk("reset.err", 16'(err), 16'd0);

        // plain wb write
        set_wb(1'b1, 3'd3, 16'hABCD);
        chk_rf("wb0", 1'b1, 3'd3, 16'hABCD);
        chk("wb0.ready", 16'(lngReady), 16'd1);
        chk("wb0.err", 16'(err), 16'd0);
        tick();

        // single lng result drains the cycle after it is queued
        set_wb(1'b0, 3'd0, 16'd0);
        set_lng(1'b1, 3'd5, 16'h1234);
        chk_rf("lng0.push", 1'b0, 3'd0, 16'd0);
        tick();
        set_lng(1'b0, 3'd0, 16'd0);
        chk_rf("lng0.pop", 1'b1, 3'd5, 16'h1234);
        chk("lng0.pend", 16'(pendingRegs), 16'h20);
        tick();
        chk_rf("lng0.idle", 1'b0, 3'd0, 16'd0);
        chk("lng0.pend_clr", 16'(pendingRegs), 16'h00);

        // starvation: two queued entries, wb holds the port
        set_wb(1'b1, 3'd0, 16'h1111);
        set_lng(1'b1, 3'd1, 16'h0101);
        tick();
        set_lng(1'b1, 3'd2, 16'h0202);
        chk("starve.ready_b", 16'(lngReady), 16'd1);
        tick();
        set_lng(1'b0, 3'd0, 16'd0);
        chk_rf("starve.c", 1'b1, 3'd0, 16'h1111);
        chk("starve.ready_c", 16'(lngReady), 16'd0);
        chk("starve.pend_c", 16'(pendingRegs), 16'h06);
        chk("starve.stall_c", 16'(stallPipe), 16'd0);
        tick();
        chk("starve.stall_d", 16'(stallPipe), 16'd0);
        tick();
        chk("starve.stall_e", 16'(stallPipe), 16'd0);
        tick();
        set_wb(1'b0, 3'd0, 16'd0);
        #1;
        chk("starve.stall_f", 16'(stallPipe), 16'd1);
        chk_rf("starve.pop1", 1'b1, 3'd1, 16'h0101);
        tick();
        set_wb(1'b1, 3'd0, 16'h2222);
        chk("starve.stall_g", 16'(stallPipe), 16'd0);
        chk("starve.ready_g", 16'(lngReady), 16'd1);
        chk_rf("starve.g", 1'b1, 3'd0, 16'h2222);
        tick();
        set_wb(1'b0, 3'd0, 16'd0);
        chk_rf("starve.pop2", 1'b1, 3'd2, 16'h0202);
        chk("starve.stall_h", 16'(stallPipe), 16'd0);
        tick();
        chk_rf("starve.empty", 1'b0, 3'd0, 16'd0);
        chk("starve.err", 16'(err), 16'd0);

        // full FIFO refuses even in the pop cycle
        set_wb(1'b1, 3'd0, 16'h5555);
        set_lng(1'b1, 3'd6, 16'h0606);
        tick();
        set_lng(1'b1, 3'd7, 16'h0707);
        tick();
        set_lng(1'b1, 3'd3, 16'h0303);
        #1;
        chk("full.ready", 16'(lngReady), 16'd0);
        tick();
        set_wb(1'b0, 3'd0, 16'd0);
        chk_rf("full.pop6", 1'b1, 3'd6, 16'h0606);
        chk("full.ready_pop", 16'(lngReady), 16'd0);
        tick();
        chk("full.ready_after", 16'(lngReady), 16'd1);
        chk_rf("full.pop7", 1'b1, 3'd7, 16'h0707);
        tick();
        set_lng(1'b0, 3'd0, 16'd0);
        chk_rf("full.pop3", 1'b1, 3'd3, 16'h0303);
        tick();
        chk_rf("full.empty", 1'b0, 3'd0, 16'd0);

        // pointer wrap: push/pop pairs keep order
        for (int i = 0; i < 6; i++) begin
            set_lng(1'b1, 3'(i), 16'hA000 + 16'(i));
            if (i > 0) chk_rf($sformatf("wrap%0d", i), 1'b1, 3'(i - 1), 16'hA000 + 16'(i - 1));
            tick();
        end
        set_lng(1'b0, 3'd0, 16'd0);
        chk_rf("wrap6", 1'b1, 3'd5, 16'hA005);
        tick();
        chk_rf("wrap.empty", 1'b0, 3'd0, 16'd0);
        chk("wrap.err", 16'(err), 16'd0);

        // WAW hazard sets sticky err
        set_lng(1'b1, 3'd4, 16'h4444);
        tick();
        set_lng(1'b0, 3'd0, 16'd0);
        set_wb(1'b1, 3'd4, 16'h9999);
        chk_rf("waw.wb", 1'b1, 3'd4, 16'h9999);
        chk("waw.err_pre", 16'(err), 16'd0);
        tick();
        set_wb(1'b0, 3'd0, 16'd0);
        chk("waw.err", 16'(err), 16'd1);
        chk_rf("waw.pop", 1'b1, 3'd4, 16'h4444);
        tick();
        chk("waw.err_hold", 16'(err), 16'd1);
        set_lng(1'b1, 3'd6, 16'h6666);
        tick();
        set_lng(1'b0, 3'd0, 16'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("waw.rst_err", 16'(err), 16'd0);
        chk("waw.rst_pend", 16'(pendingRegs), 16'h00);
        chk("waw.rst_en", 16'(rfWriteEn), 16'd0);

        // reset in the middle of a forced drain
        set_wb(1'b1, 3'd0, 16'h7777);
        set_lng(1'b1, 3'd1, 16'h1010);
        tick();
        set_lng(1'b1, 3'd2, 16'h2020);
        tick();
        set_lng(1'b0, 3'd0, 16'd0);
        tick();
        tick();
        tick();
        set_wb(1'b0, 3'd0, 16'd0);
        #1;
        chk("rststall.stall", 16'(stallPipe), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rststall.stall_clr", 16'(stallPipe), 16'd0);
        chk("rststall.ready", 16'(lngReady), 16'd1);
        chk("rststall.en", 16'(rfWriteEn), 16'd0);
        chk("rststall.pend", 16'(pendingRegs), 16'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rststall.nostale%0d", i), 16'(rfWriteEn), 16'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
